// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller for the ID-stage comparator loop.
// Decodes the ID opcode into the comparator select, resolves taken branches
// and jumps, owns the fetch PC, squashes IF/ID for one cycle after a redirect,
// locks up on HALT and counts taken control transfers (saturating).
//
// Handshake note: there is no valid/ready pair here. id_valid qualifies the
// ID-stage fields for one cycle; stall is a pure hold (no decision, PC held)
// and dominates id_valid. A decision is only ever made in RUN.
module branch_redirect_ctrl #(
   parameter int              WIDTH    = 16,
   parameter int              OFF_W    = 8,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int              PC_INC   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             id_valid,
   input  logic [3:0]       id_opcode,
   input  logic [WIDTH-1:0] id_pc,
   input  logic [OFF_W-1:0] id_offset,
   input  logic [1:0]       branch,
   output logic [1:0]       branchControl,
   output logic [WIDTH-1:0] pc,
   output logic             flush_if_id,
   output logic             halted,
   output logic [15:0]      taken_cnt,
   output logic [1:0]       dbg_state
);

   localparam logic [3:0] OP_BGT  = 4'b0100;
   localparam logic [3:0] OP_BLT  = 4'b0101;
   localparam logic [3:0] OP_BEQ  = 4'b0110;
   localparam logic [3:0] OP_JMP  = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [1:0] {
      S_RUN    = 2'b00,
      S_FLUSH  = 2'b01,
      S_HALTED = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [15:0]      taken_cnt_q, taken_cnt_d;

   logic             is_cond;
   logic             is_jmp;
   logic             is_halt;
   logic             decide;
   logic             taken;
   logic [WIDTH-1:0] off_ext;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc_seq;

   // Comparator select decode; unknown opcodes select the "always 0" compare.
   always_comb begin
      branchControl = 2'b11;
      case (id_opcode)
         OP_BLT:  branchControl = 2'b00;
         OP_BGT:  branchControl = 2'b01;
         OP_BEQ:  branchControl = 2'b10;
         default: branchControl = 2'b11;
      endcase
   end

   // Branch resolution and redirect target (word offset scaled to bytes).
   always_comb begin
      is_cond = (id_opcode == OP_BLT) || (id_opcode == OP_BGT) || (id_opcode == OP_BEQ);
      is_jmp  = (id_opcode == OP_JMP);
      is_halt = (id_opcode == OP_HALT);
      decide  = id_valid && !stall && (state_q == S_RUN);
      taken   = decide && ((is_cond && branch[0]) || is_jmp);
      off_ext = {{(WIDTH-OFF_W){id_offset[OFF_W-1]}}, id_offset};
      target  = id_pc + WIDTH'(PC_INC) + (off_ext << 1);
      pc_seq  = pc_q + WIDTH'(PC_INC);
   end

   // Next-state, next-PC and counter update.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      taken_cnt_d = taken_cnt_q;
      case (state_q)
         S_RUN: begin
            if (taken) begin
               pc_d    = target;
               state_d = S_FLUSH;
               if (taken_cnt_q != 16'hFFFF) begin
                  taken_cnt_d = taken_cnt_q + 16'd1;
               end
            end else if (decide && is_halt) begin
               state_d = S_HALTED;
            end else if (!stall) begin
               pc_d = pc_seq;
            end
         end
         S_FLUSH: begin
            // The ID-stage instruction is wrong-path here; never evaluate it.
            state_d = S_RUN;
            if (!stall) begin
               pc_d = pc_seq;
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // State, PC and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RUN;
         pc_q        <= RESET_PC;
         taken_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      pc          = pc_q;
      taken_cnt   = taken_cnt_q;
      flush_if_id = (state_q == S_FLUSH);
      halted      = (state_q == S_HALTED);
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, random traffic
// against a behavioural model, and hand sequences for halt and reset corners.
module tb_branch_redirect_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        id_valid;
   logic [3:0]  id_opcode;
   logic [15:0] id_pc;
   logic [7:0]  id_offset;
   logic [1:0]  branch;
   logic [1:0]  branchControl;
   logic [15:0] pc;
   logic        flush_if_id;
   logic        halted;
   logic [15:0] taken_cnt;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   int m_pc;
   bit m_redirected;
   bit m_halted;
   int m_cnt;

   typedef struct {
      logic        v;
      logic [3:0]  op;
      logic [15:0] ipc;
      logic [7:0]  off;
      logic [1:0]  br;
      logic        st;
      logic [1:0]  exp_bc;
      logic [15:0] exp_pc;
      logic        exp_flush;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t tbl[16];

   branch_redirect_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .id_valid      (id_valid),
      .id_opcode     (id_opcode),
      .id_pc         (id_pc),
      .id_offset     (id_offset),
      .branch        (branch),
      .branchControl (branchControl),
      .pc            (pc),
      .flush_if_id   (flush_if_id),
      .halted        (halted),
      .taken_cnt     (taken_cnt),
      .dbg_state     (dbg_state)
   );

   // Clock: 10 time-unit period, first rising edge at t=5.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [15:0] ipc,
                               input logic [7:0] off, input logic [1:0] br, input logic st,
                               input logic [1:0] bc, input logic [15:0] epc,
                               input logic efl, input logic [15:0] ecnt);
      vec_t r;
      r.v = v; r.op = op; r.ipc = ipc; r.off = off; r.br = br; r.st = st;
      r.exp_bc = bc; r.exp_pc = epc; r.exp_flush = efl; r.exp_cnt = ecnt;
      return r;
   endfunction

   // Comparator select as listed in the opcode table.
   function automatic logic [1:0] ref_bc(input logic [3:0] op);
      if (op == 4'b0101) return 2'b00;
      if (op == 4'b0100) return 2'b01;
      if (op == 4'b0110) return 2'b10;
      return 2'b11;
   endfunction

   function automatic void model_reset();
      m_pc         = 0;
      m_redirected = 0;
      m_halted     = 0;
      m_cnt        = 0;
   endfunction

   // One clock of the reference behaviour, using the inputs present at the edge.
   function automatic void model_step();
      bit cond;
      bit go;
      int off_words;
      if (m_halted) return;
      if (m_redirected) begin
         m_redirected = 0;
         if (!stall) m_pc = (m_pc + 2) % 65536;
         return;
      end
      cond      = (id_opcode == 4'b0101) || (id_opcode == 4'b0100) || (id_opcode == 4'b0110);
      go        = id_valid && !stall;
      off_words = $signed(id_offset);
      if (go && ((cond && branch[0]) || id_opcode == 4'b1000)) begin
         m_pc         = ((int'(id_pc) + 2 + 2 * off_words) % 65536 + 65536) % 65536;
         m_cnt        = (m_cnt == 65535) ? 65535 : m_cnt + 1;
         m_redirected = 1;
      end else if (go && id_opcode == 4'b1111) begin
         m_halted = 1;
      end else if (!stall) begin
         m_pc = (m_pc + 2) % 65536;
      end
   endfunction

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] ipc,
                        input logic [7:0] off, input logic [1:0] br, input logic st);
      id_valid  = v;
      id_opcode = op;
      id_pc     = ipc;
      id_offset = off;
      branch    = br;
      stall     = st;
   endtask

   task automatic drive_random();
      logic [3:0] op;
      int sel;
      sel = $urandom_range(0, 49);
      if (sel == 0)       op = 4'b1111;
      else if (sel < 10)  op = 4'b0101;
      else if (sel < 20)  op = 4'b0100;
      else if (sel < 30)  op = 4'b0110;
      else if (sel < 37)  op = 4'b1000;
      else                op = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), op, 16'($urandom), 8'($urandom),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0));
   endtask

   // Inputs are driven just after a rising edge; combinational decode is
   // sampled mid-cycle and registered outputs 1 unit after the next edge.
   task automatic model_cycle(input string tag);
      #2;
      chk({tag, " branchControl"}, 32'(branchControl), 32'(ref_bc(id_opcode)));
      @(posedge clk);
      model_step();
      #1;
      chk({tag, " pc"},        32'(pc),          32'(m_pc));
      chk({tag, " flush"},     32'(flush_if_id), 32'(m_redirected));
      chk({tag, " halted"},    32'(halted),      32'(m_halted));
      chk({tag, " taken_cnt"}, 32'(taken_cnt),   32'(m_cnt));
   endtask

   // Asynchronous reset pulse, checked while rst_n is still low.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #2;
      chk({tag, " rst pc"},     32'(pc),          32'h0);
      chk({tag, " rst flush"},  32'(flush_if_id), 32'h0);
      chk({tag, " rst halted"}, 32'(halted),      32'h0);
      chk({tag, " rst cnt"},    32'(taken_cnt),   32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 8'h0, 2'b00, 1'b0);
      model_reset();

      // Test 1: reset then idle fetch.
      repeat (2) @(posedge clk);
      #1;
      chk("reset pc",     32'(pc),          32'h0);
      chk("reset flush",  32'(flush_if_id), 32'h0);
      chk("reset halted", 32'(halted),      32'h0);
      chk("reset cnt",    32'(taken_cnt),   32'h0);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("idle pc %0d", i), 32'(pc), 32'(2 * i));
         chk($sformatf("idle flush %0d", i), 32'(flush_if_id), 32'h0);
      end

      // Directed table: starts with pc=8, taken_cnt=0, state RUN.
      tbl[0]  = mk(1, 4'b0110, 16'h0010, 8'h04, 2'b01, 0, 2'b10, 16'h001A, 1, 16'd1); // BEQ taken
      tbl[1]  = mk(0, 4'b0000, 16'h0000, 8'h00, 2'b00, 0, 2'b11, 16'h001C, 0, 16'd1);
      tbl[2]  = mk(1, 4'b0101, 16'h0040, 8'h10, 2'b00, 0, 2'b00, 16'h001E, 0, 16'd1); // BLT not taken
      tbl[3]  = mk(1, 4'b0100, 16'h0040, 8'h10, 2'b10, 0, 2'b01, 16'h0020, 0, 16'd1); // bit1 ignored
      tbl[4]  = mk(1, 4'b1000, 16'h0004, 8'hFC, 2'b00, 0, 2'b11, 16'hFFFE, 1, 16'd2); // JMP backward
      tbl[5]  = mk(0, 4'b0000, 16'h0000, 8'h00, 2'b00, 0, 2'b11, 16'h0000, 0, 16'd2); // wrap
      tbl[6]  = mk(0, 4'b0000, 16'h0000, 8'h00, 2'b00, 0, 2'b11, 16'h0002, 0, 16'd2);
      tbl[7]  = mk(1, 4'b0100, 16'h0100, 8'h10, 2'b01, 1, 2'b01, 16'h0002, 0, 16'd2); // BGT stalled
      tbl[8]  = mk(1, 4'b0100, 16'h0100, 8'h10, 2'b01, 1, 2'b01, 16'h0002, 0, 16'd2);
      tbl[9]  = mk(1, 4'b0100, 16'h0100, 8'h10, 2'b01, 0, 2'b01, 16'h0122, 1, 16'd3); // released
      tbl[10] = mk(1, 4'b0110, 16'h0200, 8'h01, 2'b01, 0, 2'b10, 16'h0124, 0, 16'd3); // BEQ in FLUSH
      tbl[11] = mk(0, 4'b0000, 16'h0000, 8'h00, 2'b00, 0, 2'b11, 16'h0126, 0, 16'd3);
      tbl[12] = mk(1, 4'b1000, 16'h0300, 8'h00, 2'b00, 0, 2'b11, 16'h0302, 1, 16'd4); // JMP +0
      tbl[13] = mk(1, 4'b0110, 16'h0500, 8'h01, 2'b01, 1, 2'b10, 16'h0302, 0, 16'd4); // FLUSH + stall
      tbl[14] = mk(0, 4'b0000, 16'h0000, 8'h00, 2'b00, 0, 2'b11, 16'h0304, 0, 16'd4);
      tbl[15] = mk(0, 4'b0110, 16'h0600, 8'h02, 2'b01, 0, 2'b10, 16'h0306, 0, 16'd4); // invalid BEQ

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].ipc, tbl[i].off, tbl[i].br, tbl[i].st);
         #2;
         chk($sformatf("vec%0d branchControl", i), 32'(branchControl), 32'(tbl[i].exp_bc));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d pc", i),     32'(pc),          32'(tbl[i].exp_pc));
         chk($sformatf("vec%0d flush", i),  32'(flush_if_id), 32'(tbl[i].exp_flush));
         chk($sformatf("vec%0d halted", i), 32'(halted),      32'h0);
         chk($sformatf("vec%0d cnt", i),    32'(taken_cnt),   32'(tbl[i].exp_cnt));
      end

      // Test 6: HALT locks the PC; reset mid-halt recovers.
      drive(0, 4'h0, 16'h0, 8'h0, 2'b00, 0);
      do_reset("pre-halt");
      drive(0, 4'h0, 16'h0, 8'h0, 2'b00, 0);
      model_cycle("pre-halt idle");
      drive(1, 4'b1111, 16'h0040, 8'h00, 2'b00, 0);
      model_cycle("halt");
      chk("halt pc frozen", 32'(pc), 32'h2);
      chk("halt asserted",  32'(halted), 32'h1);
      for (int i = 0; i < 10; i++) begin
         drive(1, 4'b1000, 16'($urandom), 8'($urandom), 2'b01, 0);
         model_cycle($sformatf("halted %0d", i));
         chk($sformatf("halted pc %0d", i), 32'(pc), 32'h2);
      end
      do_reset("mid-halt");
      drive(0, 4'h0, 16'h0, 8'h0, 2'b00, 0);
      model_cycle("post-halt");
      chk("post-halt pc", 32'(pc), 32'h2);

      // Reset while the flush cycle is in progress.
      drive(1, 4'b1000, 16'h0100, 8'h00, 2'b00, 0);
      model_cycle("jmp before reset");
      chk("flush before reset", 32'(flush_if_id), 32'h1);
      drive(0, 4'h0, 16'h0, 8'h0, 2'b00, 0);
      do_reset("mid-flush");
      model_cycle("after mid-flush reset");

      // Random traffic against the model, with periodic resets.
      for (int i = 0; i < 600; i++) begin
         if (i % 75 == 74) begin
            do_reset($sformatf("rand reset %0d", i));
         end
         drive_random();
         model_cycle($sformatf("rand %0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
